// File: rtl/fifo_serializer_if.sv
// FIFO read side plus narrow valid/ready chunk stream of the word serializer.
// master = serializer view, slave = the FIFO/consumer environment view.
interface fifo_serializer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4
);
  logic                 fifo_empty_i;
  logic [IN_WIDTH-1:0]  fifo_data_i;
  logic                 fifo_read_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [OUT_WIDTH-1:0] out_data_o;
  logic                 out_last_o;
  logic                 busy_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_read_o, out_valid_o, out_data_o, out_last_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_read_o, out_valid_o, out_data_o, out_last_o, busy_o
  );
endinterface

// File: rtl/fifo_serializer.sv
// Pops FIFO words and emits them as OUT_WIDTH chunks; first chunk 2 cycles after the read strobe.
// Backpressure: out_ready_i low holds the current chunk and valid; no new read until the last chunk moves.
module fifo_serializer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk_i,
  input logic                reset_i,
  fifo_serializer_if.master  bus
);
  localparam int CHUNKS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = $clog2(CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_e;

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_last;
  logic [OUT_WIDTH-1:0] chunk;

  assign is_last = (cnt_q == LAST_CNT);
  assign chunk   = MSB_FIRST ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH] : shreg_q[OUT_WIDTH-1:0];
  assign bus.busy_o = (state_q != IDLE);

  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    cnt_d           = cnt_q;
    bus.fifo_read_o = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.out_last_o  = 1'b0;
    bus.out_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty_i) begin
          bus.fifo_read_o = 1'b1;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        // Registered FIFO data is valid only in the cycle after the strobe.
        shreg_d = bus.fifo_data_i;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        bus.out_valid_o = 1'b1;
        bus.out_data_o  = chunk;
        bus.out_last_o  = is_last;
        if (bus.out_ready_i) begin
          if (is_last) begin
            // Prefetch the next word under the last chunk to keep one bubble per word.
            if (!bus.fifo_empty_i) begin
              bus.fifo_read_o = 1'b1;
              state_d         = WAIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset_i) begin
      bus.fifo_read_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_serializer.sv
// Two serializers (MSB-first and LSB-first) share one FIFO model and one ready/reset stream.
module tb_fifo_serializer;
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  fifo_serializer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) if_m ();
  fifo_serializer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) if_l ();

  fifo_serializer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk_i), .reset_i(reset_i), .bus(if_m)
  );
  fifo_serializer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk_i), .reset_i(reset_i), .bus(if_l)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_q[$];
  logic [3:0]  exp_m[$];
  logic [3:0]  exp_l[$];
  bit          bubble;
  bit          exp_vld;
  bit          cur_rst;
  bit          cur_rdy;

  typedef struct {
    bit          push;
    logic [15:0] word;
    bit          rdy;
    bit          rd;
    bit          vld;
    bit          last;
    bit          busy;
    logic [3:0]  dm;
    logic [3:0]  dl;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_fifo();
    if_m.fifo_empty_i = (fifo_q.size() == 0);
    if_l.fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    set_fifo();
  endtask

  // Called just after a falling edge: drive inputs, then compare against the reference.
  task automatic drive_and_check(input bit rst, input bit rdy);
    bit exp_rd;
    reset_i = rst;
    if_m.out_ready_i = rdy;
    if_l.out_ready_i = rdy;
    cur_rst = rst;
    cur_rdy = rdy;
    #1;
    exp_vld = (exp_m.size() > 0) && !bubble;
    exp_rd  = !rst && (fifo_q.size() > 0) &&
              ((exp_m.size() == 0) || (exp_vld && rdy && exp_m.size() == 1));
    chk("read_m", if_m.fifo_read_o, exp_rd);
    chk("read_l", if_l.fifo_read_o, exp_rd);
    chk("valid_m", if_m.out_valid_o, exp_vld);
    chk("valid_l", if_l.out_valid_o, exp_vld);
    chk("busy_m", if_m.busy_o, exp_m.size() > 0);
    chk("busy_l", if_l.busy_o, exp_l.size() > 0);
    chk("last_m", if_m.out_last_o, exp_vld && exp_m.size() == 1);
    chk("last_l", if_l.out_last_o, exp_vld && exp_l.size() == 1);
    if (exp_vld) begin
      chk("data_m", if_m.out_data_o, exp_m[0]);
      chk("data_l", if_l.out_data_o, exp_l[0]);
    end
  endtask

  // Clock edge, then update FIFO and expected chunk queues from what happened.
  task automatic advance();
    bit          xfer;
    bit          rd;
    logic [15:0] w;
    xfer = exp_vld && cur_rdy && !cur_rst;
    rd   = if_m.fifo_read_o;
    @(posedge clk_i);
    #1;
    if (cur_rst) begin
      exp_m.delete();
      exp_l.delete();
      bubble = 1'b0;
      w = 16'($urandom());
    end else begin
      if (xfer) begin
        void'(exp_m.pop_front());
        void'(exp_l.pop_front());
      end
      bubble = 1'b0;
      if (rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          exp_m.push_back(4'(w >> (12 - 4 * k)));
          exp_l.push_back(4'(w >> (4 * k)));
        end
        bubble = 1'b1;
      end else begin
        // Data outside the post-read cycle must be ignored by the DUT.
        w = 16'($urandom());
      end
    end
    if_m.fifo_data_i = w;
    if_l.fifo_data_i = w;
    set_fifo();
    @(negedge clk_i);
  endtask

  task automatic step(input bit rst, input bit rdy);
    drive_and_check(rst, rdy);
    advance();
  endtask

  initial begin
    logic [3:0] seq_0f[4];
    seq_0f[0] = 4'h0; seq_0f[1] = 4'hF; seq_0f[2] = 4'h0; seq_0f[3] = 4'hF;

    //            push word     rdy  rd vld last busy dm    dl
    tbl[0]  = '{1'b1, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 4'h3};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'hC};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 4'h5};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'hA};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h4};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 4'h3};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h2};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h4, 4'h1};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 4'hF};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'hE};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'hE};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hB};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};

    reset_i = 1'b1;
    if_m.out_ready_i = 1'b0;
    if_l.out_ready_i = 1'b0;
    if_m.fifo_data_i = '0;
    if_l.fifo_data_i = '0;
    bubble = 1'b0;
    exp_vld = 1'b0;
    set_fifo();

    push(16'h5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      chk("rst_read_m", if_m.fifo_read_o, 1'b0);
      chk("rst_read_l", if_l.fifo_read_o, 1'b0);
    end
    void'(fifo_q.pop_front());
    set_fifo();
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("rst_valid", if_m.out_valid_o, 1'b0);
    chk("rst_busy", if_m.busy_o, 1'b0);
    chk("rst_data", if_m.out_data_o, 4'h0);
    chk("rst_last", if_m.out_last_o, 1'b0);
    chk("rst_data_l", if_l.out_data_o, 4'h0);
    @(negedge clk_i);

    // Basic send and back-to-back words.
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].push) push(tbl[i].word);
      drive_and_check(1'b0, tbl[i].rdy);
      chk($sformatf("tbl%0d_rd", i), if_m.fifo_read_o, tbl[i].rd);
      chk($sformatf("tbl%0d_vld", i), if_m.out_valid_o, tbl[i].vld);
      chk($sformatf("tbl%0d_last", i), if_m.out_last_o, tbl[i].last);
      chk($sformatf("tbl%0d_busy", i), if_m.busy_o, tbl[i].busy);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_dm", i), if_m.out_data_o, tbl[i].dm);
        chk($sformatf("tbl%0d_dl", i), if_l.out_data_o, tbl[i].dl);
      end
      advance();
    end

    // Backpressure while chunk 0x5 is presented.
    push(16'hA5C3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_and_check(1'b0, 1'b0);
      chk("bp_data", if_m.out_data_o, 4'h5);
      chk("bp_valid", if_m.out_valid_o, 1'b1);
      chk("bp_last", if_m.out_last_o, 1'b0);
      advance();
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("bp_drained", exp_m.size(), 0);

    // Reset after chunk 0x5 has been transferred.
    push(16'hA5C3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drive_and_check(1'b0, 1'b1);
    chk("mid_rst_valid", if_m.out_valid_o, 1'b0);
    chk("mid_rst_busy", if_m.busy_o, 1'b0);
    chk("mid_rst_data", if_m.out_data_o, 4'h0);
    chk("mid_rst_read", if_m.fifo_read_o, 1'b0);
    advance();
    push(16'h0F0F);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive_and_check(1'b0, 1'b1);
      chk("mid_rst_word", if_m.out_data_o, seq_0f[k]);
      chk("mid_rst_word_vld", if_m.out_valid_o, 1'b1);
      advance();
    end
    step(1'b0, 1'b1);

    // Empty FIFO: nothing may happen.
    for (int i = 0; i < 20; i++) begin
      drive_and_check(1'b0, 1'($urandom_range(0, 1)));
      chk("empty_read", if_m.fifo_read_o, 1'b0);
      chk("empty_valid", if_m.out_valid_o, 1'b0);
      advance();
    end

    // Randomized traffic, ready and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) push(16'($urandom()));
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("final_drained", exp_m.size() + fifo_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Downstream consumer of the team's FIFO. Pops IN_WIDTH-bit words through the FIFO's read interface and emits each word as IN_WIDTH/OUT_WIDTH narrower chunks on a valid/ready stream.
- Matches the FIFO's read timing: read strobe qualified by empty, data registered and valid the cycle after the strobe.
- Typical use: FIFO output to a narrow link or transmitter stage.

Parameters:
- IN_WIDTH, 16, FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 4, output chunk width.
- MSB_FIRST, 1. 1 = most-significant chunk sent first; 0 = least-significant first.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  IN_WIDTH  FIFO registered read data. Valid the cycle after fifo_read_o.
- fifo_read_o  output  1  FIFO read strobe (combinational).
- out_valid_o  output  1  chunk valid.
- out_ready_i  input  1  downstream ready.
- out_data_o  output  OUT_WIDTH  current chunk.
- out_last_o  output  1  current chunk is the final chunk of its word.
- busy_o  output  1  word in flight (state != IDLE).

Behaviour:
- Interface: one clock (clk_i). Reset is synchronous and active-high on reset_i.
- CHUNKS = IN_WIDTH/OUT_WIDTH, with CHUNKS >= 2. Chunk counter is $clog2(CHUNKS) bits wide and counts 0..CHUNKS-1.
- States: IDLE, WAIT, SEND. Reset value is IDLE.
- Reset:
  - At the clock edge with reset_i=1, the block enters IDLE, and the shift register and counter clear to 0.
  - out_valid_o, out_last_o, busy_o and out_data_o are 0 out of reset.
  - fifo_read_o is forced to 0 in any cycle reset_i=1.
  - Reset mid-word discards the partial word. No further chunks are emitted.
- IDLE:
  - fifo_read_o = ~fifo_empty_i.
  - If it is asserted, go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - Load the shift register with fifo_data_i and clear the counter.
  - Go to SEND. fifo_read_o = 0.
- SEND:
  - out_valid_o = 1.
  - out_data_o is the top OUT_WIDTH bits of the shift register (MSB_FIRST=1) or the bottom OUT_WIDTH bits (MSB_FIRST=0).
  - out_last_o = (counter == CHUNKS-1).
- Handshake:
  - A transfer occurs when out_valid_o & out_ready_i.
  - With out_ready_i=0, out_data_o and out_last_o hold stable. out_valid_o never drops without a transfer.
- Non-last transfer: shift the register by OUT_WIDTH toward the emitting end, zero-fill, increment the counter, stay in SEND.
- Last transfer:
  - If ~fifo_empty_i: fifo_read_o = 1 in the same cycle, go to WAIT.
  - Otherwise: go to IDLE.
- fifo_read_o is asserted only when fifo_empty_i=0. The block never issues a read against an empty FIFO.
- Latency: fifo_read_o in cycle N gives the first chunk valid in cycle N+2.
- Throughput with out_ready_i held at 1 and the FIFO non-empty: one word per CHUNKS+1 cycles. The single bubble cycle is WAIT.
- fifo_data_i is sampled only in WAIT. It is ignored in all other states.
- busy_o = 1 in WAIT and SEND.
- out_ready_i is ignored outside SEND.

Test Plan:
- Basic send: reset, then one word 0xA5C3, MSB_FIRST=1, out_ready_i=1.
  - fifo_read_o pulses 1 cycle.
  - 2 cycles later, chunks 0xA, 0x5, 0xC, 0x3 appear on consecutive cycles, with out_last_o only on 0x3.
  - Block returns to IDLE with busy_o=0.
- Back-to-back: words 0x1234 and 0xBEEF queued.
  - fifo_read_o fires in the same cycle as the 0x4 transfer.
  - Exactly one bubble, then chunks 0xB, 0xE, 0xE, 0xF.
  - No read is issued after the FIFO reports empty.
- Backpressure: word 0xA5C3, with out_ready_i held 0 for 3 cycles while 0x5 is presented.
  - out_data_o=0x5 and out_valid_o=1 stay stable.
  - Sequence completes A, 5, C, 3 with no loss or duplication.
- LSB-first: MSB_FIRST=0, word 0xA5C3 → chunks 0x3, 0xC, 0x5, 0xA, with out_last_o on 0xA.
- Reset mid-word: assert reset_i after chunk 0x5 of 0xA5C3.
  - The next cycle has out_valid_o=0, busy_o=0, out_data_o=0 and fifo_read_o=0.
  - The next queued word 0x0F0F is sent intact: 0x0, 0xF, 0x0, 0xF.
- Empty FIFO: fifo_empty_i=1 for 20 cycles → fifo_read_o and out_valid_o stay 0 throughout.
